pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS-style pipeline: load-use bubbles,
// branch/jump redirect flushes and data-memory wait freezes, with event counters.
module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_ir,
  input  logic        dx_memread,
  input  logic [4:0]  dx_rd,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_hold,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_uses_rt;
  logic        w_lu_hazard;
  logic        w_mem_stall;
  logic        w_redirect;
  logic        w_flush_evt;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;

  assign w_op = if_id_ir[31:26];
  assign w_rs = if_id_ir[25:21];
  assign w_rt = if_id_ir[20:16];

  // R-type, beq, bne and sw read rt as a source operand
  assign w_uses_rt   = (w_op == 6'd0) || (w_op == 6'd4) || (w_op == 6'd5) || (w_op == 6'd43);
  assign w_lu_hazard = dx_memread && (dx_rd != 5'd0) &&
                       ((dx_rd == w_rs) || (w_uses_rt && (dx_rd == w_rt)));
  assign w_mem_stall = dmem_req && !dmem_ready;
  assign w_redirect  = branch_taken || jump;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    w_flush_evt = 1'b0;
    w_next      = RUN;
    if (rst) begin
      w_next = RUN;
    end else if (w_mem_stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      exmem_hold = 1'b1;
      w_next     = MEM_WAIT;
    end else if ((r_state != FLUSH) && w_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      w_flush_evt = 1'b1;
      w_next      = FLUSH;
    end else if (((r_state == RUN) || (r_state == MEM_WAIT)) && w_lu_hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      w_next      = LU_STALL;
    end else if (r_state == FLUSH) begin
      // second flushed slot: the wrong-path fetch now sitting in IF/ID
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (!pc_we && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_evt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle comparison against an
// action-based model plus directed scenarios with hand-computed literal checks.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_ir;
  logic        dx_memread;
  logic [4:0]  dx_rd;
  logic        branch_taken, jump, dmem_req, dmem_ready;
  logic        pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_hold;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // model state: 0 RUN, 1 load-use stall, 2 memory wait, 3 flush tail
  int m_state = 0;
  int m_stall = 0;
  int m_flush = 0;

  localparam logic [31:0] I_ADD  = {6'd0,  5'd5, 5'd1, 5'd6, 11'h020}; // add $6,$5,$1
  localparam logic [31:0] I_LW7  = {6'd35, 5'd5, 5'd7, 16'h0000};      // lw $7,0($5)
  localparam logic [31:0] I_J    = {6'd2,  26'h0000000};               // j 0
  localparam logic [31:0] I_SW5  = {6'd43, 5'd0, 5'd5, 16'h0004};      // sw $5,4($0)
  localparam logic [31:0] I_ADDI = {6'd8,  5'd1, 5'd5, 16'h0001};      // addi $5,$1,1
  localparam logic [31:0] I_NOP  = 32'h0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .if_id_ir(if_id_ir), .dx_memread(dx_memread), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .jump(jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_hold(exmem_hold), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit depends(input logic [31:0] ir, input logic mr, input logic [4:0] rd);
    bit reads_rt;
    reads_rt = ir[31:26] inside {6'd0, 6'd4, 6'd5, 6'd43};
    return mr && rd != 0 && (rd == ir[25:21] || (reads_rt && rd == ir[20:16]));
  endfunction

  // 0 nothing, 1 memory freeze, 2 redirect, 3 load-use bubble, 4 flush tail
  function automatic int action(input int st);
    if (rst) return 0;
    if (dmem_req && !dmem_ready) return 1;
    if (st == 3) return 4;
    if (branch_taken || jump) return 2;
    if (st != 1 && depends(if_id_ir, dx_memread, dx_rd)) return 3;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int a;
      logic [5:0] e;
      a = action(m_state);
      e = {!(a == 1 || a == 3), !(a == 1 || a == 3), a == 3, a == 2 || a == 4, a == 2, a == 1};
      check("outs{pc,ifid,bub,iff,idf,hold}",
            {26'd0, pc_we, ifid_we, idex_bubble, ifid_flush, idex_flush, exmem_hold}, {26'd0, e});
      check("state", {30'd0, state}, m_state);
      check("stall_cnt", {16'd0, stall_cnt}, m_stall);
      check("flush_cnt", {16'd0, flush_cnt}, m_flush);
    end
  end

  always @(posedge clk) begin
    int a;
    a = action(m_state);
    if (rst) begin
      m_state = 0; m_stall = 0; m_flush = 0;
    end else begin
      if ((a == 1 || a == 3) && m_stall < 65535) m_stall++;
      if (a == 2 && m_flush < 65535) m_flush++;
      case (a)
        1:       m_state = 2;
        2:       m_state = 3;
        3:       m_state = 1;
        default: m_state = 0;
      endcase
    end
  end

  task automatic drive(input logic r, input logic [31:0] ir, input logic mr, input logic [4:0] rd,
                       input logic bt, input logic jp, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; if_id_ir = ir; dx_memread = mr; dx_rd = rd;
    branch_taken = bt; jump = jp; dmem_req = req; dmem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; if_id_ir = I_NOP; dx_memread = 1'b0; dx_rd = 5'd0;
    branch_taken = 1'b0; jump = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;

    drive(1'b1, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_state", state, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_pc_we", pc_we, 1);

    // load-use: lw $5 then add $6,$5,$1
    drive(1'b0, I_ADD, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lu_pc_we", pc_we, 0);
    check("lu_bubble", idex_bubble, 1);
    drive(1'b0, I_ADD, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lu_state1", state, 1);
    check("lu_no_second_bubble", idex_bubble, 0);
    idle();
    check("lu_state0", state, 0);
    check("lu_stall_cnt", stall_cnt, 1);

    // operand-field variants
    drive(1'b0, I_LW7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lw_base_stall", idex_bubble, 1);
    idle();
    drive(1'b0, I_J, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("j_no_stall", pc_we, 1);
    drive(1'b0, I_ADD, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rd0_no_stall", pc_we, 1);
    drive(1'b0, I_SW5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sw_rt_stall", idex_bubble, 1);
    idle();
    drive(1'b0, I_ADDI, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    check("addi_rt_no_stall", pc_we, 1);
    check("stall_cnt_3", stall_cnt, 3);

    // taken branch
    drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("br_T_flush", {ifid_flush, idex_flush}, 2'b11);
    idle();
    check("br_T1_flush", {ifid_flush, idex_flush}, 2'b10);
    check("br_T1_state", state, 3);
    idle();
    check("br_T2_state", state, 0);
    check("br_flush_cnt", flush_cnt, 1);

    // data-memory wait of 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("mw_pc_we", pc_we, 0);
      check("mw_hold", exmem_hold, 1);
    end
    drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mw_state", state, 2);
    check("mw_stall_cnt", stall_cnt, 6);
    check("mw_release", pc_we, 1);
    idle();
    check("mw_back_run", state, 0);

    // redirect together with load-use: flush only
    drive(1'b0, I_ADD, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rl_no_bubble", idex_bubble, 0);
    check("rl_flush", idex_flush, 1);
    idle();
    idle();
    check("rl_stall_same", stall_cnt, 6);
    check("rl_flush_cnt", flush_cnt, 2);

    // jump resolving as memory wait ends
    drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("mwj_idex_flush", idex_flush, 1);
    idle();
    check("mwj_state", state, 3);
    check("mwj_flush_cnt", flush_cnt, 3);
    idle();

    // reset during memory wait
    drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rmw_state2", state, 2);
    check("rmw_defaults", {pc_we, exmem_hold}, 2'b10);
    idle();
    check("rmw_state0", state, 0);
    check("rmw_stall0", stall_cnt, 0);
    check("rmw_flush0", flush_cnt, 0);

    // saturation of stall_cnt
    for (int i = 0; i < 65540; i++)
      drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_stall", stall_cnt, 16'hFFFF);
    drive(1'b0, I_NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_stall_hold", stall_cnt, 16'hFFFF);
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
